// File: rtl/fetch_stage.sv
// Purpose     : instruction fetch - PC, single-outstanding imem req/ack, prefetch FIFO, registered ID word.
// Latency     : with a 1-cycle ack, first instruction on o_ir_id_r 3 cycles after reset; then 1 per 2 cycles.
// Backpressure: i_stall freezes the ID outputs; new requests stop issuing while the FIFO is full.
// Ports: clk/rst; i_stall, i_branch_met, i_branch_target from pipeline control;
//        o_imem_req/o_imem_addr/i_imem_ack/i_imem_data memory read port;
//        o_ir_id_r/o_ir_valid_r/o_pc_id_r registered ID-stage instruction, validity and address.
module fetch_stage #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]       NOP_INSTR = 16'hBF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_branch_met,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [15:0]       i_imem_data,
  output logic [15:0]       o_ir_id_r,
  output logic              o_ir_valid_r,
  output logic [ADDR_W-1:0] o_pc_id_r
);

  localparam int unsigned    PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {REQ_IDLE, REQ_WAIT, REQ_DROP} req_state_e;

  req_state_e        state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;

  logic [ADDR_W-1:0] fifo_pc_q [DEPTH];
  logic [15:0]       fifo_ir_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_d;

  logic              ack_vld;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [ADDR_W-1:0] branch_pc;

  // An ack only counts while a request is actually on the bus.
  assign ack_vld    = i_imem_ack & req_q;
  assign branch_pc  = i_branch_target & ~ADDR_W'(1);
  assign push       = (state_q == REQ_WAIT) & ack_vld & ~i_branch_met;
  assign fifo_empty = (count_q == '0);
  assign pop        = ~i_stall & ~i_branch_met & ~fifo_empty;

  assign o_imem_req  = req_q;
  assign o_imem_addr = addr_q;

  // Request FSM. addr_q is separate from pc_q because a branch retargets pc_q
  // while the old request must stay on the bus until its ack is swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ_IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        REQ_IDLE: begin
          if (i_branch_met) begin
            pc_q <= branch_pc;
          end else if (count_q < FULL_CNT) begin
            // Room is reserved at issue time, so the ack can always be pushed.
            state_q <= REQ_WAIT;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        REQ_WAIT: begin
          if (i_branch_met) begin
            pc_q <= branch_pc;
            if (ack_vld) begin
              state_q <= REQ_IDLE;
              req_q   <= 1'b0;
            end else begin
              state_q <= REQ_DROP;
            end
          end else if (ack_vld) begin
            pc_q    <= pc_q + ADDR_W'(2);
            state_q <= REQ_IDLE;
            req_q   <= 1'b0;
          end
        end
        REQ_DROP: begin
          if (i_branch_met) begin
            pc_q <= branch_pc;
          end
          if (ack_vld) begin
            state_q <= REQ_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= REQ_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (i_branch_met) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (i_branch_met) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ir_q[wr_ptr_q] <= i_imem_data;
      fifo_pc_q[wr_ptr_q] <= addr_q;
    end
  end

  // ID-stage register: branch flush beats stall; an empty FIFO yields a bubble
  // but keeps the last PC so the control unit still sees a sane address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ir_id_r    <= NOP_INSTR;
      o_ir_valid_r <= 1'b0;
      o_pc_id_r    <= RESET_PC;
    end else if (i_branch_met) begin
      o_ir_id_r    <= NOP_INSTR;
      o_ir_valid_r <= 1'b0;
    end else if (!i_stall) begin
      if (!fifo_empty) begin
        o_ir_id_r    <= fifo_ir_q[rd_ptr_q];
        o_pc_id_r    <= fifo_pc_q[rd_ptr_q];
        o_ir_valid_r <= 1'b1;
      end else begin
        o_ir_id_r    <= NOP_INSTR;
        o_ir_valid_r <= 1'b0;
      end
    end
  end

endmodule
